// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_e;

  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 12000;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding the UART scheduler; a push into a full queue is taken
// only when a pop happens in the same cycle.
module uart_tx_fifo
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Drains the byte queue into a UART: load data register, pulse send, wait for
// done (bounded by a timeout), with sticky overflow/timeout flags.
module uart_tx_sched
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk_i,
  input  logic                          rst,
  input  logic                          wr_i,
  input  logic [7:0]                    wdata_i,
  input  logic                          err_clr_i,
  input  logic                          uart_tx_done_i,
  output logic [7:0]                    uart_data_o,
  output logic                          we_data_uart_o,
  output logic                          uart_send_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          fifo_full_o,
  output logic                          busy_o,
  output logic                          ovf_o,
  output logic                          tmo_o
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic             tmo_set, ovf_set;

  logic [7:0]       fifo_rdata;
  logic             fifo_pop, fifo_full, fifo_empty;

  assign fifo_pop = (state_q == LOAD);
  assign ovf_set  = wr_i && fifo_full && !fifo_pop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst     (rst),
    .push_i  (wr_i),
    .pop_i   (fifo_pop),
    .wdata_i (wdata_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    data_d  = data_q;
    tmo_set = 1'b0;
    unique case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        data_d  = fifo_rdata;
        state_d = START;
      end
      START: begin
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Done takes priority over an expiring timer in the same cycle.
        if (uart_tx_done_i) begin
          state_d = IDLE;
        end else if (tmr_q == TMR_LAST) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    tmo_d = tmo_q;
    if (err_clr_i) begin
      ovf_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (tmo_set) tmo_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  // The head is shown directly during LOAD so the UART latches it with we.
  assign uart_data_o    = (state_q == LOAD) ? fifo_rdata : data_q;
  assign we_data_uart_o = (state_q == LOAD);
  assign uart_send_o    = (state_q == START);
  assign busy_o         = (state_q != IDLE) || !fifo_empty;
  assign fifo_full_o    = fifo_full;
  assign ovf_o          = ovf_q;
  assign tmo_o          = tmo_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: table of single-byte transactions plus
// hand-written sequences for overflow, full-with-pop, timeout and reset.
module tb_uart_tx_sched;

  localparam int DEPTH = 4;
  localparam int TMO   = 200;

  logic                      clk_i = 1'b0;
  logic                      rst = 1'b0;
  logic                      wr_i = 1'b0;
  logic [7:0]                wdata_i = 8'h00;
  logic                      err_clr_i = 1'b0;
  logic                      uart_tx_done_i = 1'b0;
  logic [7:0]                uart_data_o;
  logic                      we_data_uart_o;
  logic                      uart_send_o;
  logic [$clog2(DEPTH):0]    fifo_count_o;
  logic                      fifo_full_o;
  logic                      busy_o;
  logic                      ovf_o;
  logic                      tmo_o;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic [7:0] sb_exp;

  typedef struct {
    logic [7:0] data;
    int         dly;
    logic       exp_tmo;
  } vec_t;

  vec_t tbl[5];

  uart_tx_sched #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i          (clk_i),
    .rst            (rst),
    .wr_i           (wr_i),
    .wdata_i        (wdata_i),
    .err_clr_i      (err_clr_i),
    .uart_tx_done_i (uart_tx_done_i),
    .uart_data_o    (uart_data_o),
    .we_data_uart_o (we_data_uart_o),
    .uart_send_o    (uart_send_o),
    .fifo_count_o   (fifo_count_o),
    .fifo_full_o    (fifo_full_o),
    .busy_o         (busy_o),
    .ovf_o          (ovf_o),
    .tmo_o          (tmo_o)
  );

  always #50 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every data-register load must match the oldest byte still expected.
  always @(negedge clk_i) begin
    if (rst && we_data_uart_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_load: got %02h, expected no load", uart_data_o);
      end else begin
        sb_exp = sb.pop_front();
        if (uart_data_o !== sb_exp) begin
          errors++;
          $display("FAIL sb_order: got %02h, expected %02h", uart_data_o, sb_exp);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_i = 1'b1;
    wdata_i = d;
    step(1);
    wr_i = 1'b0;
  endtask

  task automatic pulse_done();
    uart_tx_done_i = 1'b1;
    step(1);
    uart_tx_done_i = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
  endtask

  // Returns positioned in the first WAIT cycle.
  task automatic wait_send();
    int n = 0;
    while (!uart_send_o && n < 50) begin
      step(1);
      n++;
    end
    check("wait_send", uart_send_o, 1'b1);
    step(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{8'h41, 100,     1'b0};
    tbl[1] = '{8'h00, 0,       1'b0};
    tbl[2] = '{8'hFF, 150,     1'b0};
    tbl[3] = '{8'hA5, TMO - 1, 1'b0};
    tbl[4] = '{8'h3C, TMO,     1'b1};

    // Reset state
    rst = 1'b0;
    step(3);
    check("rst_data",  uart_data_o,    8'h00);
    check("rst_count", fifo_count_o,   0);
    check("rst_full",  fifo_full_o,    1'b0);
    check("rst_busy",  busy_o,         1'b0);
    check("rst_we",    we_data_uart_o, 1'b0);
    check("rst_send",  uart_send_o,    1'b0);
    check("rst_ovf",   ovf_o,          1'b0);
    check("rst_tmo",   tmo_o,          1'b0);
    rst = 1'b1;
    step(1);

    // Single-byte transactions: latency, hold, done/timeout handling
    for (int i = 0; i < 5; i++) begin
      sb.push_back(tbl[i].data);
      write_byte(tbl[i].data);
      check("tbl_count1", fifo_count_o, 1);
      check("tbl_busy1",  busy_o, 1'b1);
      step(1);
      check("tbl_we",     we_data_uart_o, 1'b1);
      check("tbl_data",   uart_data_o, tbl[i].data);
      check("tbl_nosend", uart_send_o, 1'b0);
      step(1);
      check("tbl_send",   uart_send_o, 1'b1);
      check("tbl_we_off", we_data_uart_o, 1'b0);
      check("tbl_hold",   uart_data_o, tbl[i].data);
      step(1);
      if (tbl[i].dly > 0) step(tbl[i].dly);
      pulse_done();
      check("tbl_idle",   busy_o, 1'b0);
      check("tbl_tmo",    tmo_o, tbl[i].exp_tmo);
      check("tbl_hold2",  uart_data_o, tbl[i].data);
      if (tbl[i].exp_tmo) begin
        pulse_clr();
        check("tbl_tmo_clr", tmo_o, 1'b0);
      end
    end

    // Overflow while in WAIT; fifth byte dropped, set beats simultaneous clear
    sb.push_back(8'h01);
    write_byte(8'h01);
    wait_send();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back(8'h10 + 8'(i));
      wr_i = 1'b1;
      wdata_i = 8'h10 + 8'(i);
      err_clr_i = (i == 4);
      step(1);
    end
    wr_i = 1'b0;
    err_clr_i = 1'b0;
    check("ovf_set",   ovf_o, 1'b1);
    check("ovf_count", fifo_count_o, DEPTH);
    check("ovf_full",  fifo_full_o, 1'b1);
    pulse_done();
    for (int i = 0; i < 4; i++) begin
      wait_send();
      pulse_done();
    end
    check("ovf_idle",  busy_o, 1'b0);
    check("ovf_drain", sb.size(), 0);
    check("ovf_hold",  ovf_o, 1'b1);
    pulse_clr();
    check("ovf_clr",   ovf_o, 1'b0);

    // Full queue, write during LOAD is accepted
    sb.push_back(8'h20);
    write_byte(8'h20);
    wait_send();
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'h20 + 8'(i));
      write_byte(8'h20 + 8'(i));
    end
    check("fp_full",  fifo_full_o, 1'b1);
    pulse_done();
    step(1);
    check("fp_load",  we_data_uart_o, 1'b1);
    check("fp_full2", fifo_full_o, 1'b1);
    sb.push_back(8'h55);
    write_byte(8'h55);
    check("fp_count", fifo_count_o, DEPTH);
    check("fp_ovf",   ovf_o, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_send();
      pulse_done();
    end
    check("fp_idle",  busy_o, 1'b0);
    check("fp_drain", sb.size(), 0);

    // Timeout without done: flag exactly TMO cycles after entering WAIT
    sb.push_back(8'hB0);
    sb.push_back(8'hB1);
    write_byte(8'hB0);
    write_byte(8'hB1);
    wait_send();
    step(TMO - 1);
    check("tmo_early", tmo_o, 1'b0);
    step(1);
    check("tmo_set",  tmo_o, 1'b1);
    check("tmo_busy", busy_o, 1'b1);
    step(1);
    check("tmo_next_we",   we_data_uart_o, 1'b1);
    check("tmo_next_data", uart_data_o, 8'hB1);
    wait_send();
    pulse_done();
    check("tmo_hold", tmo_o, 1'b1);
    pulse_clr();
    check("tmo_clr",  tmo_o, 1'b0);

    // Reset mid-frame with bytes queued
    sb.push_back(8'hC0);
    write_byte(8'hC0);
    wait_send();
    write_byte(8'hC1);
    write_byte(8'hC2);
    write_byte(8'hC3);
    check("mr_count3", fifo_count_o, 3);
    rst = 1'b0;
    step(1);
    check("mr_count", fifo_count_o,   0);
    check("mr_full",  fifo_full_o,    1'b0);
    check("mr_busy",  busy_o,         1'b0);
    check("mr_we",    we_data_uart_o, 1'b0);
    check("mr_send",  uart_send_o,    1'b0);
    check("mr_data",  uart_data_o,    8'h00);
    check("mr_ovf",   ovf_o,          1'b0);
    check("mr_tmo",   tmo_o,          1'b0);
    rst = 1'b1;
    pulse_done();
    step(3);
    check("mr_after_busy", busy_o, 1'b0);
    check("mr_after_tmo",  tmo_o, 1'b0);
    check("mr_after_cnt",  fifo_count_o, 0);

    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
